// File: rtl/mips_pkg.sv
// Shared types and constants for the fetch stage: FSM states, next-pc source
// selects and datapath widths.
package mips_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  typedef enum logic [1:0] {SEL_SEQ, SEL_BR, SEL_J, SEL_JR} sel_t;

endpackage

// File: rtl/next_pc_mux.sv
// Next-pc target computation and priority select (JR > J > branch > sequential).
// Purely combinational; also flags misaligned or out-of-memory targets.
module next_pc_mux
  import mips_pkg::*;
#(
  parameter int unsigned IMEM_WORDS = 256
) (
  input  logic [XLEN-1:0] pc_plus4_i,
  input  logic            branch_taken_i,
  input  logic [15:0]     branch_imm_i,
  input  logic            jump_i,
  input  logic [25:0]     jump_index_i,
  input  logic            jump_reg_i,
  input  logic [XLEN-1:0] jr_target_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            bad_target_o
);

  localparam logic [XLEN-1:0] LIMIT = XLEN'(INSTR_BYTES * IMEM_WORDS);

  sel_t            sel;
  logic [XLEN-1:0] br_off;

  // Word offset, sign-extended, scaled to bytes.
  assign br_off = {{14{branch_imm_i[15]}}, branch_imm_i, 2'b00};

  always_comb begin
    sel = SEL_SEQ;
    if (jump_reg_i)          sel = SEL_JR;
    else if (jump_i)         sel = SEL_J;
    else if (branch_taken_i) sel = SEL_BR;
  end

  always_comb begin
    next_pc_o = pc_plus4_i;
    case (sel)
      SEL_JR:  next_pc_o = jr_target_i;
      SEL_J:   next_pc_o = {pc_plus4_i[31:28], jump_index_i, 2'b00};
      SEL_BR:  next_pc_o = pc_plus4_i + br_off;
      default: next_pc_o = pc_plus4_i;
    endcase
  end

  assign bad_target_o = (next_pc_o[1:0] != 2'b00) || (next_pc_o >= LIMIT);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter with BOOT/RUN/HALT control; new pc appears one cycle after the
// decision edge, en=0 stalls everything. PC_TRACE_EN adds redirect trace outputs.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned     IMEM_WORDS   = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            branch_taken,
  input  logic [15:0]     branch_imm,
  input  logic            jump,
  input  logic [25:0]     jump_index,
  input  logic            jump_reg,
  input  logic [XLEN-1:0] jr_target,
  input  logic            halt_req,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_valid,
  output logic            halted,
  output logic            fault,
  output logic [XLEN-1:0] retired
`ifdef PC_TRACE_EN
  ,
  output logic [XLEN-1:0] last_redirect_pc,
  output logic [15:0]     redirect_count
`endif
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] retired_q, retired_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] next_pc;
  logic            bad_target;
  logic            run_step, advance, commit;

  assign pc_plus4 = pc_q + XLEN'(INSTR_BYTES);

  next_pc_mux #(.IMEM_WORDS(IMEM_WORDS)) u_next_pc_mux (
    .pc_plus4_i     (pc_plus4),
    .branch_taken_i (branch_taken),
    .branch_imm_i   (branch_imm),
    .jump_i         (jump),
    .jump_index_i   (jump_index),
    .jump_reg_i     (jump_reg),
    .jr_target_i    (jr_target),
    .next_pc_o      (next_pc),
    .bad_target_o   (bad_target)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= BOOT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    if (en) state_d = RUN;
      RUN:     if (en && (halt_req || bad_target)) state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  // A halt commits without moving pc; a bad target neither commits nor moves.
  always_comb begin
    fetch_valid = (state_q == RUN);
    halted      = (state_q == HALT);
    run_step    = en && (state_q == RUN);
    commit      = run_step && (halt_req || !bad_target);
    advance     = run_step && !halt_req && !bad_target;
    pc_d        = advance ? next_pc : pc_q;
    retired_d   = commit ? retired_q + 32'd1 : retired_q;
    fault_d     = fault_q | (run_step && !halt_req && bad_target);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_VECTOR;
      retired_q <= '0;
      fault_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
    end
  end

  assign pc      = pc_q;
  assign retired = retired_q;
  assign fault   = fault_q;

`ifdef PC_TRACE_EN
  logic [XLEN-1:0] last_redirect_q;
  logic [15:0]     redirect_count_q;
  logic            redirect;

  assign redirect = advance && (jump_reg || jump || branch_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_redirect_q  <= '0;
      redirect_count_q <= '0;
    end else if (redirect) begin
      last_redirect_q <= pc_q;
      if (redirect_count_q != 16'hFFFF) redirect_count_q <= redirect_count_q + 16'd1;
    end
  end

  assign last_redirect_pc = last_redirect_q;
  assign redirect_count   = redirect_count_q;
`endif

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Sequential program-counter stage directly upstream of the instruction memory; its `pc` output drives the memory address input A.
- Each cycle it selects the next PC from four sources: sequential, branch, jump or jump-register. Registers it, gated by an enable.
- Small FSM handles the post-reset first fetch, run and halt.
- Also produces `pc_plus4`, an out-of-range fault and a retired-instruction counter for the single-cycle datapath.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 256, instruction memory depth in words; byte addresses ≥ 4*IMEM_WORDS are out of range.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- en  in  1  advance enable; low holds all state.
- branch_taken  in  1  conditional branch resolved taken this cycle.
- branch_imm  in  16  branch immediate, words, signed.
- jump  in  1  J/JAL this cycle.
- jump_index  in  26  J-type index field.
- jump_reg  in  1  JR this cycle.
- jr_target  in  32  register value for JR.
- halt_req  in  1  halt instruction decoded this cycle.
- pc  out  32  current fetch address, to instruction memory A.
- pc_plus4  out  32  pc + 4, combinational.
- fetch_valid  out  1  instruction at `pc` is to be executed.
- halted  out  1  FSM in HALT.
- fault  out  1  sticky; set on out-of-range or misaligned target.
- retired  out  32  count of instructions committed.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (`clk`, `rst_n`). Assertion at any time, including mid-operation, immediately sets:
  - pc=RESET_VECTOR, state=BOOT
  - fetch_valid=0, halted=0, fault=0, retired=0
- FSM states:
  - BOOT: one cycle after reset release with en=1; pc held; fetch_valid=0; moves to RUN. Covers memory read latency on first fetch.
  - RUN: fetch_valid=1. On each edge with en=1, pc ← next_pc and retired ← retired+1.
  - HALT: fetch_valid=0, halted=1, pc frozen. Exit only by reset.
- en=0 in any state: no register changes.
- next_pc priority, highest first:
  - jump_reg: jr_target
  - jump: {pc_plus4[31:28], jump_index, 2'b00}
  - branch_taken: pc_plus4 + (sign_extend(branch_imm) << 2)
  - otherwise: pc_plus4
- Arithmetic: all 32-bit modulo 2^32. pc=32'hFFFF_FFFC sequential → 32'h0000_0000. Branch offset may be negative.
- halt_req in RUN with en=1:
  - next state HALT; pc not updated, stays at halting instruction.
  - retired increments (halt instruction commits).
  - halt_req overrides any simultaneous branch/jump.
- Fault: if the selected next_pc[1:0]≠0 or next_pc ≥ 4*IMEM_WORDS:
  - fault ← 1; next state HALT; pc not updated; retired not incremented.
  - fault cleared only by reset.
- Inputs in BOOT and HALT are ignored.
- Latency: next_pc visible on `pc` one cycle after the decision edge.

Optional Feature:
- Macro: PC_TRACE_EN.
- Defined: adds output `last_redirect_pc` (32), holding the pc of the most recent non-sequential transfer (branch taken, jump or JR). Adds output `redirect_count` (16), counting such transfers, saturating at 16'hFFFF. Both reset to 0.
- Undefined: neither port exists; no trace logic synthesised.

Decomposition:
- Shared package `mips_pkg`:
  - FSM state enum {BOOT, RUN, HALT}
  - next-pc select enum {SEL_SEQ, SEL_BR, SEL_J, SEL_JR}
  - constants XLEN=32, INSTR_BYTES=4
- One natural sub-module, `next_pc_mux`: purely combinational target computation and priority select, also outputting the out-of-range/misalign flag. The FSM and registers stay in `pc_fetch_unit`.

Test Plan:
- Reset then 5 cycles en=1, no controls → pc: 0 (BOOT), 0, 4, 8, 12, 16; retired=4 on the last cycle; fetch_valid goes 0 then 1.
- At pc=0x10, branch_taken=1, branch_imm=16'hFFFE → pc=0x0C next cycle. Same cycle jump=1, jump_index=0x8 → pc=0x20 (jump wins over branch).
- jump_reg=1, jr_target=0x0000_0042 → fault=1, halted=1, pc unchanged, retired unchanged. jr_target=0x400 with IMEM_WORDS=256 → same fault response.
- halt_req=1 with jump=1 at pc=0x18 → halted=1, pc stays 0x18, retired+1, fetch_valid=0. Further inputs → no change.
- en=0 for 3 cycles in RUN at pc=0x8 → pc and retired constant. rst_n pulsed low mid-cycle → outputs reset immediately without waiting for a clock edge.
- PC_TRACE_EN: two taken branches then a jump → redirect_count=3, last_redirect_pc = pc of the jump instruction.
